// File: rtl/hazard_sb.sv
// Hazard and stall controller with a long-latency register scoreboard, branch/jump flushes
// and a stuck-stall watchdog. Optional stall/flush counters are enabled by HAZARD_SB_PERF_EN.
module hazard_sb #(
  parameter  int REG_W  = 6,
  parameter  int WDOG_W = 8,
  parameter  int CNT_W  = 32,
  localparam int NREG   = 1 << REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        jump_ID,
  input  logic              br_taken_EX,
  input  logic [REG_W-1:0]  rs_ID,
  input  logic [REG_W-1:0]  rt_ID,
  input  logic              rs_use_ID,
  input  logic              rt_use_ID,
  input  logic              long_ID,
  input  logic [REG_W-1:0]  long_dst_ID,
  input  logic              load_EX,
  input  logic [REG_W-1:0]  rt_EX,
  input  logic              long_done,
  input  logic [REG_W-1:0]  long_done_dst,
  input  logic              cache_stall,
  input  logic              alu_stall,
  output logic              stall_pc,
  output logic              stall_FD,
  output logic              stall_IE,
  output logic              stall_EM,
  output logic              stall_MW,
  output logic              flush_FD,
  output logic              flush_IE,
  output logic [NREG-1:0]   sb_busy,
  output logic              wdog_err,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  logic rs_hit, rt_hit, waw_hit;
  logic lu, sb, be, jmp, issue;
  logic [NREG-1:0]   set_mask, clr_mask;
  logic [WDOG_W-1:0] wdog_cnt;

  // A register completing this cycle is forwarded from WB, so it no longer blocks.
  assign rs_hit  = rs_use_ID && (rs_ID != '0) && sb_busy[rs_ID] &&
                   !(long_done && (long_done_dst == rs_ID));
  assign rt_hit  = rt_use_ID && (rt_ID != '0) && sb_busy[rt_ID] &&
                   !(long_done && (long_done_dst == rt_ID));
  assign waw_hit = long_ID && sb_busy[long_dst_ID] &&
                   !(long_done && (long_done_dst == long_dst_ID));

  assign lu  = load_EX && (rt_EX != '0) &&
               ((rs_use_ID && (rt_EX == rs_ID)) || (rt_use_ID && (rt_EX == rt_ID)));
  assign sb  = rs_hit || rt_hit || waw_hit;
  assign be  = cache_stall || alu_stall;
  assign jmp = (jump_ID == 2'b01) || (jump_ID == 2'b10);

  assign stall_pc = lu || sb || be;
  assign stall_FD = stall_pc;
  assign stall_IE = be;
  assign stall_EM = be;
  assign stall_MW = be;
  assign flush_IE = (lu || sb || br_taken_EX) && !be;
  assign flush_FD = (br_taken_EX || jmp) && !be;

  // An ID instruction squashed by a taken branch must not claim its destination.
  assign issue = long_ID && !stall_FD && !br_taken_EX;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue && (long_dst_ID != '0)) set_mask[long_dst_ID] = 1'b1;
    if (long_done)                    clr_mask[long_done_dst] = 1'b1;
  end

  // NOTE: the scoreboard is state, not storage: it must be reset so stale entries cannot stall.
  always_ff @(posedge clk) begin
    if (!rst_n) sb_busy <= '0;
    else        sb_busy <= (sb_busy & ~clr_mask) | set_mask;  // set wins on collision
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else if (stall_pc) begin
      if (wdog_cnt != WDOG_MAX)              wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if (wdog_cnt == (WDOG_MAX - WDOG_W'(1))) wdog_err <= 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end

`ifdef HAZARD_SB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (stall_pc && (cnt_stall != '1))              cnt_stall <= cnt_stall + CNT_W'(1);
      if ((flush_FD || flush_IE) && (cnt_flush != '1)) cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end
`else
  assign cnt_stall = '0;
  assign cnt_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: combinational vector table plus scoreboard,
// watchdog, reset and perf-counter sequences.
module tb_hazard_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  jump_ID;
  logic        br_taken_EX;
  logic [5:0]  rs_ID, rt_ID, long_dst_ID, rt_EX, long_done_dst;
  logic        rs_use_ID, rt_use_ID, long_ID, load_EX, long_done;
  logic        cache_stall, alu_stall;
  logic        stall_pc, stall_FD, stall_IE, stall_EM, stall_MW;
  logic        flush_FD, flush_IE;
  logic [63:0] sb_busy;
  logic        wdog_err;
  logic [31:0] cnt_stall, cnt_flush;

  int passed = 0;
  int total  = 0;

  hazard_sb dut (
    .clk(clk), .rst_n(rst_n), .jump_ID(jump_ID), .br_taken_EX(br_taken_EX),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_use_ID(rs_use_ID), .rt_use_ID(rt_use_ID),
    .long_ID(long_ID), .long_dst_ID(long_dst_ID), .load_EX(load_EX), .rt_EX(rt_EX),
    .long_done(long_done), .long_done_dst(long_done_dst),
    .cache_stall(cache_stall), .alu_stall(alu_stall),
    .stall_pc(stall_pc), .stall_FD(stall_FD), .stall_IE(stall_IE),
    .stall_EM(stall_EM), .stall_MW(stall_MW), .flush_FD(flush_FD), .flush_IE(flush_IE),
    .sb_busy(sb_busy), .wdog_err(wdog_err), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] jump;
    logic       br;
    logic [5:0] rs, rt;
    logic       rs_use, rt_use, load;
    logic [5:0] rt_ex;
    logic       cache, alu;
    logic [6:0] exp;  // {stall_pc, stall_FD, stall_IE, stall_EM, stall_MW, flush_FD, flush_IE}
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    jump_ID = 2'b00; br_taken_EX = 1'b0; rs_ID = '0; rt_ID = '0;
    rs_use_ID = 1'b0; rt_use_ID = 1'b0; long_ID = 1'b0; long_dst_ID = '0;
    load_EX = 1'b0; rt_EX = '0; long_done = 1'b0; long_done_dst = '0;
    cache_stall = 1'b0; alu_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {stall_pc, stall_FD, stall_IE, stall_EM, stall_MW, flush_FD, flush_IE};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    //         jump   br    rs     rt     rsu   rtu   load  rt_ex  cache alu   expected
    vecs[0]  = '{2'b00, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'b0000000};
    vecs[1]  = '{2'b00, 1'b0, 6'd8,  6'd0,  1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 7'b1100001};
    vecs[2]  = '{2'b00, 1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 7'b0000000};
    vecs[3]  = '{2'b00, 1'b0, 6'd0,  6'd5,  1'b0, 1'b1, 1'b1, 6'd5,  1'b0, 1'b0, 7'b1100001};
    vecs[4]  = '{2'b00, 1'b0, 6'd5,  6'd5,  1'b0, 1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 7'b0000000};
    vecs[5]  = '{2'b00, 1'b1, 6'd8,  6'd0,  1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 7'b1100011};
    vecs[6]  = '{2'b01, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'b0000010};
    vecs[7]  = '{2'b10, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'b0000010};
    vecs[8]  = '{2'b11, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'b0000000};
    vecs[9]  = '{2'b01, 1'b1, 6'd8,  6'd0,  1'b1, 1'b0, 1'b1, 6'd8,  1'b1, 1'b0, 7'b1111100};
    vecs[10] = '{2'b00, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 7'b1111100};
    vecs[11] = '{2'b00, 1'b1, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 7'b0000011};
    vecs[12] = '{2'b00, 1'b0, 6'd9,  6'd0,  1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 7'b0000000};

    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_sb_busy", sb_busy, 64'h0);
    check("reset_wdog", {63'h0, wdog_err}, 64'h0);
    check("reset_cnt_stall", {32'h0, cnt_stall}, 64'h0);
    check("reset_cnt_flush", {32'h0, cnt_flush}, 64'h0);

    // Combinational table with an empty scoreboard and no long ops.
    for (int i = 0; i < 13; i++) begin
      jump_ID = vecs[i].jump; br_taken_EX = vecs[i].br;
      rs_ID = vecs[i].rs; rt_ID = vecs[i].rt;
      rs_use_ID = vecs[i].rs_use; rt_use_ID = vecs[i].rt_use;
      load_EX = vecs[i].load; rt_EX = vecs[i].rt_ex;
      cache_stall = vecs[i].cache; alu_stall = vecs[i].alu;
      #1;
      check($sformatf("vec%0d", i), {57'h0, outs()}, {57'h0, vecs[i].exp});
    end
    idle();
    tick();

    // Scoreboard dependence on HI (32).
    long_ID = 1'b1; long_dst_ID = 6'd32;
    #1 check("issue32_no_stall", {63'h0, stall_FD}, 64'h0);
    tick();
    idle();
    #1 check("sb32_set", {63'h0, sb_busy[32]}, 64'h1);
    rs_ID = 6'd32; rs_use_ID = 1'b1;
    #1 check("dep_stall", {62'h0, stall_FD, flush_IE}, 64'h3);
    tick();
    check("dep_stall_hold", {62'h0, stall_pc, stall_IE}, 64'h2);
    long_done = 1'b1; long_done_dst = 6'd32;
    #1 check("fwd_no_stall", {63'h0, stall_FD}, 64'h0);
    tick();
    long_done = 1'b0;
    #1 check("sb32_clear", {63'h0, sb_busy[32]}, 64'h0);
    check("dep_released", {63'h0, stall_FD}, 64'h0);
    idle();

    // Set/clear collision on 9, then WAW on busy 9.
    long_ID = 1'b1; long_dst_ID = 6'd9; long_done = 1'b1; long_done_dst = 6'd9;
    tick();
    idle();
    #1 check("collision_set_wins", sb_busy, 64'h200);
    long_ID = 1'b1; long_dst_ID = 6'd9;
    #1 check("waw_stall", {62'h0, stall_FD, flush_IE}, 64'h3);
    long_ID = 1'b0; long_done = 1'b1; long_done_dst = 6'd9;
    tick();
    idle();
    #1 check("sb9_clear", sb_busy, 64'h0);
    long_ID = 1'b1; long_dst_ID = 6'd0;
    tick();
    idle();
    #1 check("dst0_not_set", sb_busy, 64'h0);

    // Taken branch squashes issue, with and without a load-use.
    long_ID = 1'b1; long_dst_ID = 6'd12; br_taken_EX = 1'b1;
    #1 check("br_flush", {57'h0, outs()}, {57'h0, 7'b0000011});
    tick();
    idle();
    #1 check("br_no_issue", sb_busy, 64'h0);
    long_ID = 1'b1; long_dst_ID = 6'd13; br_taken_EX = 1'b1;
    load_EX = 1'b1; rt_EX = 6'd7; rs_ID = 6'd7; rs_use_ID = 1'b1;
    #1 check("br_lu_flush", {62'h0, flush_FD, flush_IE}, 64'h3);
    tick();
    idle();
    #1 check("br_lu_no_issue", sb_busy, 64'h0);
    tick();

    // Watchdog: 254 stalled cycles is below the limit, 255 trips it.
    alu_stall = 1'b1;
    repeat (254) tick();
    check("wdog_254", {63'h0, wdog_err}, 64'h0);
    idle();
    tick();
    check("wdog_254_release", {63'h0, wdog_err}, 64'h0);
    alu_stall = 1'b1;
    repeat (255) tick();
    check("wdog_255", {63'h0, wdog_err}, 64'h1);
    idle();
    tick();
    check("wdog_sticky", {63'h0, wdog_err}, 64'h1);

    // Reset with three busy entries.
    for (int d = 3; d <= 5; d++) begin
      long_ID = 1'b1; long_dst_ID = 6'(d);
      tick();
    end
    idle();
    #1 check("three_busy", sb_busy, 64'h38);
    rst_n = 1'b0;
    tick();
    check("rst_sb_clear", sb_busy, 64'h0);
    check("rst_wdog_clear", {63'h0, wdog_err}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Perf counters: 5 stall cycles then 2 flush cycles.
    alu_stall = 1'b1;
    repeat (5) tick();
    idle();
    jump_ID = 2'b01;
    repeat (2) tick();
    idle();
    #1;
`ifdef HAZARD_SB_PERF_EN
    check("cnt_stall", {32'h0, cnt_stall}, 64'd5);
    check("cnt_flush", {32'h0, cnt_flush}, 64'd2);
`else
    check("cnt_stall_tied", {32'h0, cnt_stall}, 64'd0);
    check("cnt_flush_tied", {32'h0, cnt_flush}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
